// File: rtl/exec_mem_unit_pkg.sv
// ============================================================================
// Module   : exec_mem_unit_pkg
// Purpose  : Shared operation codes for the execute/memory datapath slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package exec_mem_unit_pkg;

   typedef enum logic [1:0] {
      EXT_ZERO  = 2'd0,
      EXT_SIGN  = 2'd1,
      EXT_HIGH  = 2'd2,
      EXT_ZERO2 = 2'd3
   } ext_op_e;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_NOR   = 4'd5,
      ALU_SLL   = 4'd6,
      ALU_SRL   = 4'd7,
      ALU_SRA   = 4'd8,
      ALU_SLT   = 4'd9,
      ALU_SLTU  = 4'd10,
      ALU_PASSB = 4'd11,
      ALU_MOVZ  = 4'd12,
      ALU_MOVN  = 4'd13,
      ALU_RSV14 = 4'd14,
      ALU_RSV15 = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      LS_WORD  = 2'd0,
      LS_HALF  = 2'd1,
      LS_BYTE  = 2'd2,
      LS_WORD2 = 2'd3
   } ls_width_e;

endpackage

`default_nettype wire

// File: rtl/exec_mem_unit_alu_core.sv
// ============================================================================
// Module   : alu_core
// Purpose  : Integer ALU with shifts, set-less-than and conditional moves.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_core
   import exec_mem_unit_pkg::*;
(
   input  logic [3:0]  i_alu_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_c,
   input  logic [4:0]  i_shift,
   input  logic        i_shiftv,
   output logic [31:0] o_result,
   output logic        o_move_judge
);

   logic [4:0] w_sa;

   assign w_sa = i_shiftv ? i_a[4:0] : i_shift;

   always_comb begin
      o_result     = 32'h0000_0000;
      o_move_judge = 1'b0;
      case (alu_op_e'(i_alu_op))
         ALU_ADD:   o_result = i_a + i_b;
         ALU_SUB:   o_result = i_a - i_b;
         ALU_AND:   o_result = i_a & i_b;
         ALU_OR:    o_result = i_a | i_b;
         ALU_XOR:   o_result = i_a ^ i_b;
         ALU_NOR:   o_result = ~(i_a | i_b);
         ALU_SLL:   o_result = i_b << w_sa;
         ALU_SRL:   o_result = i_b >> w_sa;
         ALU_SRA:   o_result = $unsigned($signed(i_b) >>> w_sa);
         ALU_SLT:   o_result = {31'd0, $signed(i_a) < $signed(i_b)};
         ALU_SLTU:  o_result = {31'd0, i_a < i_b};
         ALU_PASSB: o_result = i_b;
         // Untaken move keeps rd's current value and flags the squash.
         ALU_MOVZ: begin
            o_result     = (i_b == 32'd0) ? i_a : i_c;
            o_move_judge = (i_b != 32'd0);
         end
         ALU_MOVN: begin
            o_result     = (i_b != 32'd0) ? i_a : i_c;
            o_move_judge = (i_b == 32'd0);
         end
         default:   o_result = 32'h0000_0000;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/exec_mem_unit_data_mem.sv
// ============================================================================
// Module   : data_mem
// Purpose  : Word-organised data memory with byte/half/word store merge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem
   import exec_mem_unit_pkg::*;
#(
   parameter int DM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_we,
   input  logic        i_stall,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_din,
   input  logic [2:0]  i_width,
   input  logic [31:0] i_pc,
   output logic [31:0] o_dout,
   output logic [1:0]  o_load_select
);

   localparam int c_IDX_W = $clog2(DM_WORDS);

   logic [31:0]        r_mem [DM_WORDS];
   logic [c_IDX_W-1:0] w_idx;
   logic [31:0]        w_merged;
   logic               w_unused;

   assign w_idx         = i_addr[c_IDX_W+1:2];
   assign o_dout        = r_mem[w_idx];
   assign o_load_select = i_addr[1:0];
   // Upper address bits alias; load signedness and PC are not needed here.
   assign w_unused      = ^{i_addr[31:c_IDX_W+2], i_width[2], i_pc};

   always_comb begin
      w_merged = r_mem[w_idx];
      case (ls_width_e'(i_width[1:0]))
         LS_HALF: begin
            if (i_addr[1]) w_merged[31:16] = i_din[15:0];
            else           w_merged[15:0]  = i_din[15:0];
         end
         LS_BYTE: begin
            case (i_addr[1:0])
               2'd0:    w_merged[7:0]   = i_din[7:0];
               2'd1:    w_merged[15:8]  = i_din[7:0];
               2'd2:    w_merged[23:16] = i_din[7:0];
               default: w_merged[31:24] = i_din[7:0];
            endcase
         end
         default: w_merged = i_din;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= 32'h0000_0000;
      end else if (i_we && !i_stall) begin
         r_mem[w_idx] <= w_merged;
      end
   end

endmodule

`default_nettype wire

// File: rtl/exec_mem_unit_imm_ext.sv
// ============================================================================
// Module   : imm_ext
// Purpose  : 16-to-32 bit immediate extender (zero / sign / upper-half).
// Revision : 1.0
// ============================================================================
`default_nettype none

module imm_ext
   import exec_mem_unit_pkg::*;
(
   input  logic [1:0]  i_ext_op,
   input  logic [15:0] i_imm16,
   output logic [31:0] o_ext
);

   always_comb begin
      o_ext = {16'h0000, i_imm16};
      case (ext_op_e'(i_ext_op))
         EXT_SIGN: o_ext = {{16{i_imm16[15]}}, i_imm16};
         EXT_HIGH: o_ext = {i_imm16, 16'h0000};
         default:  o_ext = {16'h0000, i_imm16};
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/exec_mem_unit.sv
// ============================================================================
// Module   : exec_mem_unit
// Purpose  : Execute/memory slice: immediate extender, ALU and data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exec_mem_unit
   import exec_mem_unit_pkg::*;
#(
   parameter int DM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  ExtOp,
   input  logic [15:0] imm16,
   output logic [31:0] EXT_OUT,
   input  logic [3:0]  ALUOp,
   input  logic [31:0] inputA,
   input  logic [31:0] inputB,
   input  logic [31:0] inputC,
   input  logic [4:0]  shift,
   input  logic        SHIFTV,
   output logic [31:0] ALU_result,
   output logic        move_judge,
   input  logic        DMWr,
   input  logic [31:0] DMAddr,
   input  logic [31:0] DIN,
   input  logic [2:0]  L_S_SL,
   input  logic [31:0] PC,
   input  logic        stall_DM,
   output logic [31:0] DOUT,
   output logic [1:0]  LoadSelect
);

   imm_ext u_imm_ext (
      .i_ext_op (ExtOp),
      .i_imm16  (imm16),
      .o_ext    (EXT_OUT)
   );

   alu_core u_alu_core (
      .i_alu_op     (ALUOp),
      .i_a          (inputA),
      .i_b          (inputB),
      .i_c          (inputC),
      .i_shift      (shift),
      .i_shiftv     (SHIFTV),
      .o_result     (ALU_result),
      .o_move_judge (move_judge)
   );

   data_mem #(
      .DM_WORDS (DM_WORDS)
   ) u_data_mem (
      .clk           (clk),
      .reset         (reset),
      .i_we          (DMWr),
      .i_stall       (stall_DM),
      .i_addr        (DMAddr),
      .i_din         (DIN),
      .i_width       (L_S_SL),
      .i_pc          (PC),
      .o_dout        (DOUT),
      .o_load_select (LoadSelect)
   );

endmodule

`default_nettype wire

// File: tb/tb_exec_mem_unit.sv
// ============================================================================
// Module   : tb_exec_mem_unit
// Purpose  : Directed self-checking bench for exec_mem_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exec_mem_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ExtOp;
   logic [15:0] imm16;
   logic [31:0] EXT_OUT;
   logic [3:0]  ALUOp;
   logic [31:0] inputA, inputB, inputC;
   logic [4:0]  shift;
   logic        SHIFTV;
   logic [31:0] ALU_result;
   logic        move_judge;
   logic        DMWr;
   logic [31:0] DMAddr, DIN, PC;
   logic [2:0]  L_S_SL;
   logic        stall_DM;
   logic [31:0] DOUT;
   logic [1:0]  LoadSelect;

   int checks   = 0;
   int failures = 0;

   exec_mem_unit dut (
      .clk        (clk),
      .reset      (reset),
      .ExtOp      (ExtOp),
      .imm16      (imm16),
      .EXT_OUT    (EXT_OUT),
      .ALUOp      (ALUOp),
      .inputA     (inputA),
      .inputB     (inputB),
      .inputC     (inputC),
      .shift      (shift),
      .SHIFTV     (SHIFTV),
      .ALU_result (ALU_result),
      .move_judge (move_judge),
      .DMWr       (DMWr),
      .DMAddr     (DMAddr),
      .DIN        (DIN),
      .L_S_SL     (L_S_SL),
      .PC         (PC),
      .stall_DM   (stall_DM),
      .DOUT       (DOUT),
      .LoadSelect (LoadSelect)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c);
      ALUOp = op; inputA = a; inputB = b; inputC = c;
      #1;
   endtask

   // Drive a store at the falling edge, commit it on the next rising edge.
   task automatic store(input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] width, input logic stall);
      @(negedge clk);
      DMWr = 1'b1; DMAddr = addr; DIN = data; L_S_SL = width; stall_DM = stall;
      @(posedge clk);
      #1;
      DMWr = 1'b0; stall_DM = 1'b0;
   endtask

   task automatic read(input logic [31:0] addr);
      DMAddr = addr;
      #1;
   endtask

   initial begin
      reset = 1'b1; ExtOp = 2'd0; imm16 = 16'h0; ALUOp = 4'd0;
      inputA = 32'd0; inputB = 32'd0; inputC = 32'd0; shift = 5'd0; SHIFTV = 1'b0;
      DMWr = 1'b0; DMAddr = 32'd0; DIN = 32'd0; L_S_SL = 3'd0; PC = 32'h0000_3000;
      stall_DM = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      read(32'd0);          check("reset_word0", DOUT, 32'h0);
      read(32'h0000_3FFC);  check("reset_wordtop", DOUT, 32'h0);

      imm16 = 16'h8001;
      ExtOp = 2'd0; #1 check("ext_zero", EXT_OUT, 32'h0000_8001);
      ExtOp = 2'd1; #1 check("ext_sign", EXT_OUT, 32'hFFFF_8001);
      ExtOp = 2'd2; #1 check("ext_high", EXT_OUT, 32'h8001_0000);
      ExtOp = 2'd3; #1 check("ext_zero3", EXT_OUT, 32'h0000_8001);
      imm16 = 16'h7FFF; ExtOp = 2'd1; #1 check("ext_sign_pos", EXT_OUT, 32'h0000_7FFF);

      alu(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);  check("add_wrap", ALU_result, 32'h0);
      check("add_mj", {31'd0, move_judge}, 32'd0);
      alu(4'd1, 32'hFFFF_FFFF, 32'd1, 32'd0);  check("sub", ALU_result, 32'hFFFF_FFFE);
      alu(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);  check("slt", ALU_result, 32'd1);
      alu(4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0); check("sltu", ALU_result, 32'd0);
      alu(4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0);  check("slt_rev", ALU_result, 32'd0);
      alu(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0); check("and", ALU_result, 32'h00F0_1200);
      alu(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0); check("or",  ALU_result, 32'hFFF0_FF34);
      alu(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0); check("xor", ALU_result, 32'hFF00_ED34);
      alu(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0); check("nor", ALU_result, 32'h000F_00CB);
      alu(4'd11, 32'h1, 32'hCAFE_BABE, 32'd0);        check("passb", ALU_result, 32'hCAFE_BABE);
      alu(4'd14, 32'h5, 32'h6, 32'h7);                check("op14", ALU_result, 32'h0);
      alu(4'd15, 32'h5, 32'h6, 32'h7);                check("op15", ALU_result, 32'h0);

      shift = 5'd4; SHIFTV = 1'b0;
      alu(4'd8, 32'd0, 32'h8000_0000, 32'd0); check("sra", ALU_result, 32'hF800_0000);
      alu(4'd7, 32'd0, 32'h8000_0000, 32'd0); check("srl", ALU_result, 32'h0800_0000);
      alu(4'd6, 32'd0, 32'h0000_0003, 32'd0); check("sll_imm", ALU_result, 32'h0000_0030);
      SHIFTV = 1'b1;
      alu(4'd6, 32'd33, 32'h8000_0000, 32'd0); check("sll_var", ALU_result, 32'h0);
      alu(4'd7, 32'd33, 32'h8000_0000, 32'd0); check("srl_var", ALU_result, 32'h4000_0000);
      SHIFTV = 1'b0;

      alu(4'd12, 32'd5, 32'd0, 32'd9); check("movz_t", ALU_result, 32'd5);
      check("movz_t_mj", {31'd0, move_judge}, 32'd0);
      alu(4'd12, 32'd5, 32'd3, 32'd9); check("movz_n", ALU_result, 32'd9);
      check("movz_n_mj", {31'd0, move_judge}, 32'd1);
      alu(4'd13, 32'd5, 32'd3, 32'd9); check("movn_t", ALU_result, 32'd5);
      check("movn_t_mj", {31'd0, move_judge}, 32'd0);
      alu(4'd13, 32'd5, 32'd0, 32'd9); check("movn_n", ALU_result, 32'd9);
      check("movn_n_mj", {31'd0, move_judge}, 32'd1);

      // Old word must still be visible before the committing edge.
      @(negedge clk);
      DMWr = 1'b1; DMAddr = 32'd0; DIN = 32'h1122_3344; L_S_SL = 3'd0;
      #1 check("sw_before_edge", DOUT, 32'h0);
      @(posedge clk); #1 DMWr = 1'b0;
      check("sw", DOUT, 32'h1122_3344);

      store(32'd3, 32'hFFFF_FFAA, 3'd2, 1'b0);
      check("sb_lane3", DOUT, 32'hAA22_3344);
      check("ls_3", {30'd0, LoadSelect}, 32'd3);
      store(32'd0, 32'h1234_BEEF, 3'd5, 1'b0);
      check("sh_low", DOUT, 32'hAA22_BEEF);
      check("ls_0", {30'd0, LoadSelect}, 32'd0);
      store(32'd1, 32'h0000_0055, 3'd2, 1'b0);
      check("sb_lane1", DOUT, 32'hAA22_55EF);
      store(32'd7, 32'hDEAD_BEEF, 3'd3, 1'b0);
      read(32'd4); check("sw_misaligned", DOUT, 32'hDEAD_BEEF);
      store(32'd7, 32'h0000_1234, 3'd1, 1'b0);
      read(32'd4); check("sh_high", DOUT, 32'h1234_BEEF);
      check("ls_1_after_read", {30'd0, LoadSelect}, 32'd0);
      store(32'd0, 32'h0BAD_F00D, 3'd0, 1'b1);
      read(32'd0); check("stall_blocks", DOUT, 32'hAA22_55EF);
      read(32'h0000_4000); check("alias_read", DOUT, 32'hAA22_55EF);
      check("alias_ls", {30'd0, LoadSelect}, 32'd0);
      store(32'h0000_4004, 32'h5555_AAAA, 3'd0, 1'b0);
      read(32'd4); check("alias_write", DOUT, 32'h5555_AAAA);

      // Reset with a simultaneous store: the store is dropped.
      @(negedge clk);
      reset = 1'b1; DMWr = 1'b1; DMAddr = 32'd0; DIN = 32'h7777_7777; L_S_SL = 3'd0;
      @(posedge clk); #1;
      reset = 1'b0; DMWr = 1'b0;
      read(32'd0); check("reset_clears0", DOUT, 32'h0);
      read(32'd4); check("reset_clears1", DOUT, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
